multicycle_sequencer: RTL and testbench

Control and execute engine that drives the 8-bit, 32-entry register file through its `state`/`rs`/`rt`/`rd`/`result` interface and consumes `rsv`/`rtv`/`done`. It fetches 32-bit MIPS-format instructions over a valid-qualified port, decodes a small ALU subset, and sequences FETCH→DECODE→RF→EX→WB per instruction. On a halt instruction it runs the OUTPUT handshake and captures the value the register file returns.

---
 rtl/multicycle_sequencer_pkg.sv | 81 ++++++++
 rtl/multicycle_sequencer_alu8.sv | 26 ++
 rtl/multicycle_sequencer.sv | 121 ++++++++++++
 tb/tb_multicycle_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - shared state codes, opcodes and decode helper
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_RF        = 3'd2,
    ST_EX        = 3'd3,
    ST_WB        = 3'd4,
    ST_OUTPUT    = 3'd5,
    ST_HALT_DONE = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] OUT_REG_IDX = 5'd2;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    rtype;
    logic    halt;
    logic    invalid;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] ir);
    decode_t d;
    d.op      = ALU_ADD;
    d.use_imm = 1'b0;
    d.rtype   = 1'b0;
    d.halt    = 1'b0;
    d.invalid = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        d.rtype = 1'b1;
        case (ir[5:0])
          FN_ADD:  d.op = ALU_ADD;
          FN_SUB:  d.op = ALU_SUB;
          FN_AND:  d.op = ALU_AND;
          FN_OR:   d.op = ALU_OR;
          FN_SLT:  d.op = ALU_SLT;
          FN_SLL:  d.op = ALU_SLL;
          default: d.invalid = 1'b1;
        endcase
      end
      OP_ADDI: begin d.op = ALU_ADD; d.use_imm = 1'b1; end
      OP_SLTI: begin d.op = ALU_SLT; d.use_imm = 1'b1; end
      OP_ANDI: begin d.op = ALU_AND; d.use_imm = 1'b1; end
      OP_ORI:  begin d.op = ALU_OR;  d.use_imm = 1'b1; end
      OP_HALT: d.halt = 1'b1;
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_alu8.sv
// rtl/multicycle_sequencer_alu8.sv - combinational 8-bit ALU for the decoded subset
import multicycle_sequencer_pkg::*;

module alu8 (
  input  alu_op_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [4:0] shamt,
  output logic [7:0] y
);

  always_comb begin
    y = 8'd0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {7'd0, ($signed(a) < $signed(b))};
      // Shifting an 8-bit value by 8 or more empties it.
      ALU_SLL: y = (shamt >= 5'd8) ? 8'd0 : (b << shamt[2:0]);
      default: y = 8'd0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - FETCH/DECODE/RF/EX/WB sequencer with halt output handshake
import multicycle_sequencer_pkg::*;

module multicycle_sequencer #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_data,
  input  logic            instr_valid,
  input  logic [7:0]      rsv,
  input  logic [7:0]      rtv,
  input  logic            done,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [7:0]      result,
  output logic            instruction_invalid,
  output logic [7:0]      out_value,
  output logic            finished,
  output logic [15:0]     retired
);

  state_e      cur_state;
  logic [31:0] ir;
  alu_op_e     alu_op;
  logic        use_imm;
  logic        out_armed;
  decode_t     dec;
  logic [7:0]  alu_b;
  logic [7:0]  alu_y;

  assign state = cur_state;

  always_comb begin
    dec = decode_instr(ir);
  end

  assign alu_b = use_imm ? ir[7:0] : rtv;

  alu8 u_alu (
    .op    (alu_op),
    .a     (rsv),
    .b     (alu_b),
    .shamt (ir[10:6]),
    .y     (alu_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state           <= ST_FETCH;
      pc                  <= PC_W'(RESET_PC);
      ir                  <= 32'd0;
      alu_op              <= ALU_ADD;
      use_imm             <= 1'b0;
      out_armed           <= 1'b0;
      rs                  <= 5'd0;
      rt                  <= 5'd0;
      rd                  <= 5'd0;
      result              <= 8'd0;
      instruction_invalid <= 1'b0;
      out_value           <= 8'd0;
      finished            <= 1'b0;
      retired             <= 16'd0;
    end else begin
      case (cur_state)
        ST_FETCH: begin
          instruction_invalid <= 1'b0;
          if (instr_valid) begin
            ir        <= instr_data;
            pc        <= pc + PC_W'(1);
            cur_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          rs                  <= ir[25:21];
          rt                  <= ir[20:16];
          rd                  <= dec.rtype ? ir[15:11] : ir[20:16];
          alu_op              <= dec.op;
          use_imm             <= dec.use_imm;
          instruction_invalid <= dec.invalid;
          if (dec.halt) begin
            out_armed <= 1'b0;
            retired   <= sat_inc16(retired);
            cur_state <= ST_OUTPUT;
          end else begin
            cur_state <= ST_RF;
          end
        end
        ST_RF: cur_state <= ST_EX;
        ST_EX: begin
          // rsv/rtv are only valid on this edge, one cycle after the RF sample.
          result    <= alu_y;
          cur_state <= ST_WB;
        end
        ST_WB: begin
          retired             <= sat_inc16(retired);
          instruction_invalid <= 1'b0;
          cur_state           <= ST_FETCH;
        end
        ST_OUTPUT: begin
          // First OUTPUT edge only arms; a sticky done left over from an
          // earlier run must not capture the stale rsv.
          if (!out_armed) begin
            out_armed <= 1'b1;
          end else if (done) begin
            out_value <= rsv;
            finished  <= 1'b1;
            cur_state <= ST_HALT_DONE;
          end
        end
        ST_HALT_DONE: cur_state <= ST_HALT_DONE;
        default:      cur_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed bench with behavioural register file
import multicycle_sequencer_pkg::*;

module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_data;
  logic        instr_valid = 1'b0;
  logic [7:0]  rsv = 8'd0;
  logic [7:0]  rtv = 8'd0;
  logic        done = 1'b0;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic [4:0]  rs, rt, rd;
  logic [7:0]  result;
  logic        instruction_invalid;
  logic [7:0]  out_value;
  logic        finished;
  logic [15:0] retired;

  logic [31:0] imem [256];
  logic [7:0]  regs [32];

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  assign instr_data = imem[pc];

  multicycle_sequencer #(.PC_W(8), .RESET_PC(0)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr_data          (instr_data),
    .instr_valid         (instr_valid),
    .rsv                 (rsv),
    .rtv                 (rtv),
    .done                (done),
    .pc                  (pc),
    .state               (state),
    .rs                  (rs),
    .rt                  (rt),
    .rd                  (rd),
    .result              (result),
    .instruction_invalid (instruction_invalid),
    .out_value           (out_value),
    .finished            (finished),
    .retired             (retired)
  );

  // Register file model: never reset, done is sticky.
  always @(posedge clk) begin
    if (state == ST_RF) begin
      rsv <= regs[rs];
      rtv <= regs[rt];
    end
    if (state == ST_WB && !instruction_invalid && rd != 5'd0)
      regs[rd] <= result;
    if (state == ST_OUTPUT) begin
      rsv  <= regs[OUT_REG_IDX];
      done <= 1'b1;
    end
  end

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {OP_RTYPE, s, t, d, sh, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = {OP_HALT, 26'd0};
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_to_finish(input string tag, output int cyc);
    cyc = 0;
    while (finished !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
    check(tag, finished, 1);
  endtask

  task automatic wait_for(input string tag, input logic [2:0] st, input logic [7:0] want_pc);
    int n;
    n = 0;
    while (!(state === st && pc === want_pc) && n < 100) begin
      step();
      n++;
    end
    check(tag, (n < 100), 1);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) regs[i] = 8'd0;
    clear_imem();
    #2;

    // Reset values
    apply_reset();
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_rs_rt_rd", {rs, rt, rd}, 0);
    check("rst_result", result, 0);
    check("rst_invalid", instruction_invalid, 0);
    check("rst_out_fin", {out_value, finished}, 0);
    check("rst_retired", retired, 0);

    // Program A: 5 + 7 = 12
    clear_imem();
    imem[0] = itype(OP_ADDI, 5'd0, 5'd1, 16'd5);
    imem[1] = itype(OP_ADDI, 5'd0, 5'd2, 16'd7);
    imem[2] = rtype(5'd1, 5'd2, 5'd2, 5'd0, FN_ADD);
    imem[3] = {OP_HALT, 26'd0};
    instr_valid = 1'b1;
    apply_reset();
    run_to_finish("a_finish", cyc);
    check("a_cycles", cyc, 19);
    check("a_out", out_value, 12);
    check("a_retired", retired, 4);
    check("a_state", state, 6);
    check("a_r1", regs[1], 5);
    step();
    step();
    check("a_halt_sticky", {state, finished}, {3'd6, 1'b1});

    // Program B: 0xFF + 2 wraps to 1
    clear_imem();
    imem[0] = itype(OP_ADDI, 5'd0, 5'd2, 16'hFFFF);
    imem[1] = itype(OP_ADDI, 5'd2, 5'd2, 16'd2);
    apply_reset();
    run_to_finish("b_finish", cyc);
    check("b_out", out_value, 1);
    check("b_retired", retired, 3);

    // Program C: signed slti, 0x80 < 1
    clear_imem();
    imem[0] = itype(OP_ADDI, 5'd0, 5'd1, 16'h0080);
    imem[1] = itype(OP_SLTI, 5'd1, 5'd2, 16'd1);
    apply_reset();
    run_to_finish("c_finish", cyc);
    check("c_out", out_value, 1);

    // Program D: remaining ALU operations
    clear_imem();
    imem[0]  = itype(OP_ADDI, 5'd0, 5'd1, 16'h000F);
    imem[1]  = itype(OP_ADDI, 5'd0, 5'd3, 16'h003C);
    imem[2]  = rtype(5'd1, 5'd3, 5'd4, 5'd0, FN_AND);
    imem[3]  = rtype(5'd1, 5'd3, 5'd5, 5'd0, FN_OR);
    imem[4]  = rtype(5'd1, 5'd3, 5'd6, 5'd0, FN_SUB);
    imem[5]  = rtype(5'd0, 5'd1, 5'd7, 5'd4, FN_SLL);
    imem[6]  = rtype(5'd0, 5'd1, 5'd8, 5'd9, FN_SLL);
    imem[7]  = itype(OP_ANDI, 5'd3, 5'd9, 16'h000F);
    imem[8]  = itype(OP_ORI, 5'd1, 5'd10, 16'h00F0);
    imem[9]  = rtype(5'd6, 5'd1, 5'd11, 5'd0, FN_SLT);
    regs[8] = 8'hAA;
    apply_reset();
    run_to_finish("d_finish", cyc);
    check("d_and", regs[4], 8'h0C);
    check("d_or", regs[5], 8'h3F);
    check("d_sub", regs[6], 8'hD3);
    check("d_sll4", regs[7], 8'hF0);
    check("d_sll9", regs[8], 8'h00);
    check("d_andi", regs[9], 8'h0C);
    check("d_ori", regs[10], 8'hFF);
    check("d_slt", regs[11], 8'h01);
    check("d_retired", retired, 11);

    // Undefined opcode 0x3E targeting r2
    clear_imem();
    imem[0] = itype(OP_ADDI, 5'd0, 5'd2, 16'd9);
    imem[1] = itype(6'h3E, 5'd0, 5'd2, 16'h0077);
    apply_reset();
    wait_for("inv_reach_ex", ST_EX, 8'd2);
    check("inv_ex_flag", instruction_invalid, 1);
    step();
    check("inv_wb_state", state, 4);
    check("inv_wb_flag", instruction_invalid, 1);
    check("inv_wb_rd", rd, 2);
    step();
    step();
    check("inv_cleared", {state, instruction_invalid}, {3'd1, 1'b0});
    run_to_finish("inv_finish", cyc);
    check("inv_r2", regs[2], 9);
    check("inv_out", out_value, 9);
    check("inv_retired", retired, 3);

    // instr_valid held low in FETCH
    clear_imem();
    imem[0] = itype(OP_ADDI, 5'd0, 5'd2, 16'h0021);
    instr_valid = 1'b0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_state", state, 0);
      check("hold_pc", pc, 0);
    end
    instr_valid = 1'b1;
    step();
    check("resume_state", state, 1);
    check("resume_pc", pc, 1);
    instr_valid = 1'b0;
    step();
    instr_valid = 1'b1;
    run_to_finish("hold_finish", cyc);
    check("hold_out", out_value, 8'h21);

    // Reset during EX, then a rerun with done still set
    clear_imem();
    imem[0] = itype(OP_ADDI, 5'd0, 5'd3, 16'h0055);
    apply_reset();
    wait_for("abort_reach_ex", ST_EX, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_state", state, 0);
    check("abort_pc", pc, 0);
    check("abort_regidx", {rs, rt, rd}, 0);
    check("abort_out", {out_value, finished, instruction_invalid}, 0);
    check("abort_retired", retired, 0);
    clear_imem();
    imem[0] = itype(OP_ADDI, 5'd0, 5'd2, 16'd3);
    step();
    reset = 1'b0;
    check("abort_no_wb", regs[3], 8'h3C);
    check("stale_done_high", done, 1);
    run_to_finish("rerun_finish", cyc);
    check("rerun_cycles", cyc, 9);
    check("rerun_out", out_value, 3);
    check("rerun_retired", retired, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
